// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the systolic array datapath
// Contents: DW_DEFAULT (psum width matching the PE), psum_t (one psum word).
package systolic_pkg;

  localparam int DW_DEFAULT = 32;

  typedef logic [DW_DEFAULT-1:0] psum_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - LEN-stage register shift used to de-skew one array column
// Ports: clk, reset (async, active-high), din (DW bits in), dout (din delayed LEN cycles).
// LEN=0 makes dout a plain wire of din.
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int LEN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  if (LEN == 0) begin : g_wire
    // clk/reset are not needed when there is no storage
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign dout = din;
  end else begin : g_reg
    logic [DW-1:0] stage [LEN];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < LEN; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < LEN; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[LEN-1];
  end

endmodule

// File: rtl/psum_deskew_collector.sv
// rtl/psum_deskew_collector.sv - de-skews the bottom-row psums into aligned rows and buffers them
// Ports: clk, reset (async, active-high); bot_valid + psum_in (skewed bottom-row bus, column j
// at bits [j*DW +: DW], valid j cycles after column 0); m_valid/m_ready/m_data (buffered aligned
// rows, same packing); occupancy (rows held); overflow (sticky row-drop flag), clear_ovf (sync clear).
module psum_deskew_collector #(
  parameter int DW    = systolic_pkg::DW_DEFAULT,
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bot_valid,
  input  logic [COLS*DW-1:0]       psum_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [COLS*DW-1:0]       m_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  input  logic                     clear_ovf
);
  import systolic_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [COLS*DW-1:0] aligned_row;
  logic               row_done;

  // Column j arrives j cycles late, so it waits COLS-1-j cycles to line up with the last column.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    skew_delay_line #(.DW(DW), .LEN(COLS-1-j)) u_dly (
      .clk   (clk),
      .reset (reset),
      .din   (psum_in[j*DW +: DW]),
      .dout  (aligned_row[j*DW +: DW])
    );
  end

  // The valid bit travels alongside column 0; it marks the cycle the whole row is aligned.
  skew_delay_line #(.DW(1), .LEN(COLS-1)) u_vpipe (
    .clk   (clk),
    .reset (reset),
    .din   (bot_valid),
    .dout  (row_done)
  );

  logic [COLS*DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;

  assign full    = (count == FULL_CNT);
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;
  // A full FIFO still takes the row when the head leaves on the same edge.
  assign push_ok = row_done & (~full | pop);
  assign drop    = row_done & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= aligned_row;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A drop on the same edge as clear_ovf wins so the loss is never hidden.
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Memory is not reset; gate the head so an empty FIFO shows zeros.
  assign m_data    = m_valid ? mem[rd_ptr] : '0;
  assign occupancy = count;

endmodule

// File: doc/psum_deskew_collector.md
Name: psum_deskew_collector

Overview:
- Sits below the bottom row of the weight-stationary systolic array and reads the per-column psum_out bus.
- Results for one input vector leave the array skewed: column j is valid j cycles after column 0.
- The block de-skews the columns into one aligned row vector and buffers it in a small FIFO.
- It presents the buffered rows downstream with a valid/ready handshake and flags any loss caused by backpressure, because the array itself cannot stall.

Parameters:
- DW, 32, bit width of each psum (matches PE DW).
- COLS, 4, number of array columns; must be ≥ 1.
- DEPTH, 4, FIFO depth in row vectors; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- bot_valid  in  1  column 0 of the bottom row carries a valid psum this cycle; column j of the same vector is valid exactly j cycles later.
- psum_in  in  COLS*DW  bottom-row psum_out bus; column j occupies bits [j*DW +: DW].
- m_valid  out  1  the FIFO head row is available.
- m_ready  in  1  the downstream consumer accepts the head row.
- m_data  out  COLS*DW  head row, de-skewed, same column packing as psum_in.
- occupancy  out  $clog2(DEPTH)+1  number of rows currently held in the FIFO.
- overflow  out  1  sticky flag: at least one completed row was dropped.
- clear_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset: all delay-line stages, FIFO pointers and the valid pipe clear. m_valid=0, m_data=0, occupancy=0, overflow=0. A reset mid-operation discards in-flight and buffered rows with no partial output afterwards.
- De-skew:
  - Column j passes through a register delay of (COLS-1-j) cycles, so column COLS-1 gets no delay.
  - bot_valid passes through a COLS-1 stage valid pipe.
  - At cycle t0+COLS-1, where t0 is the cycle bot_valid was sampled high, all columns of that vector are aligned and row_done=1.
- Back-to-back vectors: bot_valid may be high on consecutive cycles. The delay lines are pure shift registers, so every vector in flight is kept; the valid pipe carries one bit per cycle.
- No data is sampled when the valid bit is low. Delay-line contents on invalid cycles are don't-care and must never reach the FIFO.
- Push: on row_done, the aligned row is written to the FIFO tail on the same edge that ends cycle t0+COLS-1.
- Latency: for an empty FIFO, m_valid=1 and m_data equals that row in cycle t0+COLS.
- Pop: a handshake occurs when m_valid and m_ready are both high at a rising edge; the head then advances.
- m_data is the registered or FIFO-read head, stable while m_valid=1 and m_ready=0.
- m_valid drops in the cycle after the last row is popped.
- Full with push and no pop: the row is dropped, overflow is set on that edge, and occupancy stays at DEPTH.
- Full with push and pop in the same cycle: the push is accepted, there is no overflow, and occupancy is unchanged.
- Empty with push and m_ready high: there is no bypass. The row appears the next cycle and occupancy goes 0→1.
- Pointers wrap modulo DEPTH; occupancy saturates at DEPTH and never underflows.
- clear_ovf has priority below a simultaneous overflow event: if both happen in the same cycle, overflow stays 1.
- No arithmetic is performed; psum bits pass through unmodified.

Decomposition:
- Shared package (systolic_pkg):
  - DW default.
  - function clog2 helper, if the tool lacks $clog2.
  - typedef psum_t = logic [DW-1:0].
- Sub-module skew_delay_line with parameters DW and LEN: a LEN-stage register shift with async reset. LEN=0 degenerates to a wire. It is instantiated once per column with LEN=COLS-1-j.
- The FIFO stays inline in this block.

Test Plan:
- Single vector:
  - Stimulus: COLS=4, bot_valid at cycle 10; columns 0..3 driven with 0x11, 0x22, 0x33, 0x44 at cycles 10, 11, 12, 13 respectively; m_ready=1.
  - Required: m_valid=1 only in cycle 14, with m_data={0x44,0x33,0x22,0x11}.
- Back-to-back:
  - Stimulus: bot_valid high for 3 consecutive cycles; vector k column j value = 16k+j; m_ready=1.
  - Required: 3 consecutive m_valid cycles carrying vectors 0, 1, 2 in order with no corruption.
- Backpressure and overflow:
  - Stimulus: m_ready=0; push 5 vectors with DEPTH=4.
  - Required: occupancy reaches 4, overflow=1 after the 5th row_done, and draining returns vectors 0..3 only.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; assert m_ready in the same cycle as a row_done.
  - Required: overflow stays 0, occupancy stays 4, and the new row is popped last.
- Hold and clear:
  - Stimulus: m_ready toggling 0/1 every cycle with 2 rows queued.
  - Required: m_data is stable while stalled.
  - Stimulus: clear_ovf pulse after an overflow.
  - Required: overflow returns to 0 on the next edge.
- Reset mid-flight:
  - Stimulus: assert reset 2 cycles after bot_valid.
  - Required: that vector never appears, and m_valid=0 and occupancy=0 immediately on reset.
